instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and program loader: the inverse of the CPU's immediate sign-extension path. It accepts decoded instruction fields (4-bit ALU opcode, two 5-bit register fields, a 32-bit signed immediate), range-checks the immediate against the field width the opcode implies, and packs a 32-bit instruction word. Packed words are written to instruction memory at consecutive word addresses through a valid/ready write port. It sits between the program source (testbench or boot loader) and instruction memory. It guarantees that every word it writes sign-extends back to the original immediate.

## Interface
Parameters:
- MEM_SIZE, 4096: instruction memory size in bytes; last writable address is MEM_SIZE-4.
- ADDR_W, 12: byte address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that begins a load session at address 0.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- op_i  in  4  ALU opcode (LW=0, SW=1, LI=2, ADDU=3, ADDIU=4, SLL=5, MUL=6, BGE=7, J=8, MULI=9).
- ra_i  in  5  first register field.
- rb_i  in  5  second register field.
- imm_i  in  32  signed immediate.
- wr_valid_o  out  1  memory write valid.
- wr_ready_i  in  1  memory accepts write.
- wr_addr_o  out  ADDR_W  byte address, always 4-aligned.
- wr_data_o  out  32  packed instruction word.
- full_o  out  1  last address written; session closed.
- err_o  out  1  one-cycle pulse per out-of-range immediate.
- err_cnt_o  out  8  saturating count of out-of-range immediates this session.

## Operation
- Field width N by opcode: J → 28; LI → 23; all others → 18.
- Packing: J → {op, imm[27:0]}; LI → {op, ra_i, imm[22:0]}; others → {op, ra_i, rb_i, imm[17:0]}.
- Range check: imm_i is in range iff imm_i[31:N-1] are all equal.
- States:
  - IDLE: the state after reset; in_ready_o=0.
  - LOAD: in_ready_o = !wr_valid_o || wr_ready_i.
  - FULL: in_ready_o=0; full_o=1.
- Transitions:
  - IDLE → LOAD on start_i.
  - LOAD → FULL when the write to MEM_SIZE-4 completes (wr_valid_o && wr_ready_i).
  - start_i in any state → LOAD, with address=0, err_cnt_o=0, wr_valid_o cleared (an in-flight word is dropped).
  - start_i forces in_ready_o=0 in the cycle it is asserted.
- An accepted in-range request loads the output register. wr_addr_o holds the current address.
- The address increments by 4 on each completed write and never wraps: the session ends in FULL.
- Out-of-range handling depends on the macro; see Configuration. err_o pulses in the cycle after acceptance. err_cnt_o increments and saturates at 255.
- Opcodes 10–15 are packed with the 18-bit rule.

## Timing
- Reset values: in_ready_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, full_o=0, err_o=0, err_cnt_o=0, state IDLE.
- Latency: accepted request → wr_valid_o asserted the next cycle.
- Throughput: one word per cycle while wr_ready_i=1.
- wr_valid_o, wr_addr_o and wr_data_o are held stable until wr_ready_i.
- Acceptance and completion in the same cycle: the new word replaces the completed one, and wr_addr_o advances by 4.
- A stall (wr_ready_i=0 while wr_valid_o=1) drops in_ready_o combinationally.
- The final write completes → full_o=1 the next cycle; no further requests are accepted.
- rst_i asserted mid-session: everything returns to reset values the next cycle and in-flight data is discarded.

## Configuration
- IMM_SAT_EN defined: an out-of-range immediate is clamped to the field limit, +(2^(N-1)-1) or −2^(N-1), then packed and written. err_o still pulses and err_cnt_o still counts.
- IMM_SAT_EN undefined: an out-of-range request is consumed (handshake completes) but produces no write, and the address does not advance. err_o pulses and err_cnt_o counts.

## Test plan
- Reset, start_i, LI with ra=3 and imm=-5 → wr_data_o=0x21FFFFFB at wr_addr_o=0x000, one cycle after acceptance.
- J with imm=0x07FFFFFF, then ADDIU with ra=1, rb=2, imm=0x1FFFF → 0x87FFFFFF at 0x000, then 0x4089FFFF at 0x004. Sign-extending each word's immediate field returns the original imm.
- ADDIU with imm=0x20000:
  - IMM_SAT_EN undefined → no write, err_o pulse, err_cnt_o=1, next valid word lands at 0x000.
  - IMM_SAT_EN defined → imm field 0x1FFFF written.
- Hold wr_ready_i=0 for 3 cycles with wr_valid_o=1 → in_ready_o=0 and outputs stable. Release → back-to-back writes resume with no loss.
- Stream 1024 valid words → full_o=1 after the write to 0xFFC, in_ready_o=0. A following start_i returns the block to LOAD at address 0 with err_cnt_o=0.
- Assert rst_i while wr_valid_o=1 and the address is 0x010 → all outputs 0, state IDLE, no write issued.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: range-checks imm per opcode and packs words to sequential imem addresses. Optional IMM_SAT_EN clamps out-of-range imms.
// Latency 1 cycle accept->wr_valid_o; in_ready_o drops combinationally on a write stall, on start_i, and outside a session.
module instr_encoder #(
  parameter int MEM_SIZE = 4096,
  parameter int ADDR_W   = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        op_i,
  input  logic [4:0]        ra_i,
  input  logic [4:0]        rb_i,
  input  logic [31:0]       imm_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              full_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  localparam logic [3:0]        OP_LI     = 4'd2;
  localparam logic [3:0]        OP_J      = 4'd8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 4);

  state_t      state;
  logic        oor;
  logic [27:0] clamp_val;
  logic [27:0] imm_eff;
  logic [31:0] packed_word;
  logic        accept;
  logic        wr_fire;
  logic        load_word;

  // Range check looks only at the bits above the field's sign bit.
  always_comb begin
    oor       = 1'b0;
    clamp_val = 28'h0;
    case (op_i)
      OP_J: begin
        oor       = !((&imm_i[31:27]) || !(|imm_i[31:27]));
        clamp_val = imm_i[31] ? 28'h800_0000 : 28'h7FF_FFFF;
      end
      OP_LI: begin
        oor       = !((&imm_i[31:22]) || !(|imm_i[31:22]));
        clamp_val = imm_i[31] ? 28'hFC0_0000 : 28'h03F_FFFF;
      end
      default: begin
        oor       = !((&imm_i[31:17]) || !(|imm_i[31:17]));
        clamp_val = imm_i[31] ? 28'hFFE_0000 : 28'h001_FFFF;
      end
    endcase
  end

`ifdef IMM_SAT_EN
  assign imm_eff   = oor ? clamp_val : imm_i[27:0];
  assign load_word = accept;
`else
  assign imm_eff   = imm_i[27:0];
  assign load_word = accept && !oor;
`endif

  always_comb begin
    packed_word = {op_i, ra_i, rb_i, imm_eff[17:0]};
    case (op_i)
      OP_J:    packed_word = {op_i, imm_eff};
      OP_LI:   packed_word = {op_i, ra_i, imm_eff[22:0]};
      default: packed_word = {op_i, ra_i, rb_i, imm_eff[17:0]};
    endcase
  end

  // No acceptance while the final word is still in flight, so nothing can slip past the last address.
  assign in_ready_o = (state == LOAD) && !start_i &&
                      (!wr_valid_o || (wr_ready_i && (wr_addr_o != LAST_ADDR)));
  assign accept  = in_valid_i && in_ready_o;
  assign wr_fire = wr_valid_o && wr_ready_i;
  assign full_o  = (state == FULL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      err_o      <= 1'b0;
      err_cnt_o  <= '0;
    end else if (start_i) begin
      state      <= LOAD;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      err_o      <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      err_o <= accept && oor;
      if (accept && oor && (err_cnt_o != 8'hFF))
        err_cnt_o <= err_cnt_o + 8'd1;
      if (wr_fire) begin
        if (wr_addr_o == LAST_ADDR)
          state <= FULL;
        else
          wr_addr_o <= wr_addr_o + ADDR_W'(4);
      end
      if (load_word) begin
        wr_valid_o <= 1'b1;
        wr_data_o  <= packed_word;
      end else if (wr_fire) begin
        wr_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes model-predicted writes, negedge monitor pops and compares.
module tb_instr_encoder;
  localparam int MEM_SIZE = 4096;
  localparam int ADDR_W   = 12;

  logic              clk = 1'b0;
  logic              rst_i, start_i, in_valid_i, in_ready_o;
  logic [3:0]        op_i;
  logic [4:0]        ra_i, rb_i;
  logic [31:0]       imm_i;
  logic              wr_valid_o, wr_ready_i;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              full_o, err_o;
  logic [7:0]        err_cnt_o;

  instr_encoder #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .ra_i(ra_i), .rb_i(rb_i), .imm_i(imm_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .full_o(full_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { longint addr; longint data; longint imm; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int err_model = 0;
  bit rdy_force = 1'b0;
  bit rdy_val = 1'b1;

  function automatic int width_of(input int op);
    return (op == 8) ? 28 : ((op == 2) ? 23 : 18);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    wr_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_ready_i = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every completed write must match the oldest prediction.
  bit                prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;
  exp_t              mon_e;
  longint            mon_f;
  int                mon_n;
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_valid", wr_valid_o, 1);
      chk("hold_addr", wr_addr_o, prev_addr);
      chk("hold_data", wr_data_o, prev_data);
    end
    if (wr_valid_o && wr_ready_i && !rst_i && !start_i) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("wr_addr", wr_addr_o, mon_e.addr);
        chk("wr_data", wr_data_o, mon_e.data);
        mon_n = width_of(int'(wr_data_o[31:28]));
        mon_f = longint'(wr_data_o) % (longint'(1) << mon_n);
        if (mon_f >= (longint'(1) << (mon_n - 1))) mon_f = mon_f - (longint'(1) << mon_n);
        chk("sext_roundtrip", mon_f, mon_e.imm);
      end
    end
    prev_stall = wr_valid_o && !wr_ready_i && !rst_i && !start_i;
    prev_addr  = wr_addr_o;
    prev_data  = wr_data_o;
  end

  task automatic send(input logic [3:0] op, input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] imm);
    longint v, lo, hi, q, f, w;
    int n, cyc;
    bit oor, wr, got;
    n  = width_of(int'(op));
    v  = longint'($signed(imm));
    lo = -(longint'(1) << (n - 1));
    hi = -lo - 1;
    oor = (v < lo) || (v > hi);
`ifdef IMM_SAT_EN
    q  = (v < lo) ? lo : ((v > hi) ? hi : v);
    wr = 1'b1;
`else
    q  = v;
    wr = !oor;
`endif
    f = (q < 0) ? q + (longint'(1) << n) : q;
    w = longint'(op) * 268435456;
    if (n == 28)      w = w + f;
    else if (n == 23) w = w + longint'(ra) * 8388608 + f;
    else              w = w + longint'(ra) * 8388608 + longint'(rb) * 262144 + f;
    in_valid_i = 1'b1; op_i = op; ra_i = ra; rb_i = rb; imm_i = imm;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      if (in_ready_o) got = 1'b1;
      cyc++;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      in_valid_i = 1'b0;
      tick();
      return;
    end
    if (wr) begin
      sbq.push_back('{longint'(wr_cnt) * 4, w, q});
      wr_cnt++;
    end
    if (oor) err_model++;
    tick();
    in_valid_i = 1'b0;
    chk("err_pulse", err_o, oor);
    chk("err_cnt", err_cnt_o, (err_model > 255) ? 255 : err_model);
    if (wr) chk("latency_valid", wr_valid_o, 1);
  endtask

  task automatic send_rand;
    int sel, n;
    logic [31:0] imm, lo32, hi32;
    logic [3:0] op;
    op   = 4'($urandom_range(0, 15));
    n    = width_of(int'(op));
    hi32 = 32'((longint'(1) << (n - 1)) - 1);
    lo32 = ~hi32;
    sel  = $urandom_range(0, 9);
    if (sel < 6)       imm = 32'($urandom_range(0, 2000)) - 32'd1000;
    else if (sel == 6) imm = ($urandom_range(0, 1) != 0) ? hi32 : hi32 + 32'd1;
    else if (sel == 7) imm = ($urandom_range(0, 1) != 0) ? lo32 : lo32 - 32'd1;
    else               imm = $urandom;
    send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
  endtask

  task automatic drain;
    int cyc = 0;
    while (sbq.size() != 0 && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("drain_left", sbq.size(), 0);
  endtask

  task automatic pulse_start;
    tick();
    start_i = 1'b1;
    @(negedge clk);
    chk("start_blocks_ready", in_ready_o, 0);
    tick();
    start_i   = 1'b0;
    wr_cnt    = 0;
    err_model = 0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0;
    op_i = '0; ra_i = '0; rb_i = '0; imm_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    in_valid_i = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_wr_valid", wr_valid_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    in_valid_i = 1'b0;
    tick();

    // Directed words from the plan
    rdy_force = 1'b1; rdy_val = 1'b1;
    pulse_start();
    send(4'd2, 5'd3, 5'd0, 32'hFFFF_FFFB);
    send(4'd8, 5'd0, 5'd0, 32'h07FF_FFFF);
    send(4'd4, 5'd1, 5'd2, 32'h0001_FFFF);
    drain();

    // Out-of-range as the first request of a session
    pulse_start();
    send(4'd4, 5'd1, 5'd2, 32'h0002_0000);
    send(4'd3, 5'd4, 5'd5, 32'd7);
    drain();

    // Write stall
    rdy_val = 1'b0;
    send(4'd6, 5'd1, 5'd1, 32'd100);
    in_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready_o, 0);
      chk("stall_valid", wr_valid_o, 1);
    end
    in_valid_i = 1'b0;
    tick();
    rdy_val = 1'b1;
    send(4'd5, 5'd2, 5'd3, 32'hFFFF_FF00);
    send(4'd9, 5'd7, 5'd8, 32'd12345);
    drain();

    // Randomized stream filling memory
    rdy_force = 1'b0;
    pulse_start();
    while (wr_cnt < MEM_SIZE / 4) send_rand();
    drain();
    in_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_flag", full_o, 1);
      chk("full_in_ready", in_ready_o, 0);
      chk("full_addr", wr_addr_o, MEM_SIZE - 4);
    end
    chk("full_err_cnt", err_cnt_o, (err_model > 255) ? 255 : err_model);
    in_valid_i = 1'b0;
    tick();
    rdy_force = 1'b1; rdy_val = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("restart_full", full_o, 0);
    chk("restart_addr", wr_addr_o, 0);
    chk("restart_err_cnt", err_cnt_o, 0);
    chk("restart_in_ready", in_ready_o, 1);
    tick();

    // Reset while a word at 0x010 is pending
    for (int i = 0; i < 4; i++) send(4'd3, 5'(i), 5'(i + 1), 32'(i * 3));
    drain();
    rdy_val = 1'b0;
    send(4'd7, 5'd2, 5'd3, 32'hFFFF_FFD8);
    @(negedge clk);
    chk("pre_rst_addr", wr_addr_o, 32'h10);
    chk("pre_rst_valid", wr_valid_o, 1);
    tick();
    rst_i = 1'b1;
    sbq.delete();
    tick();
    chk("mid_rst_valid", wr_valid_o, 0);
    chk("mid_rst_addr", wr_addr_o, 0);
    chk("mid_rst_data", wr_data_o, 0);
    chk("mid_rst_full", full_o, 0);
    chk("mid_rst_err_cnt", err_cnt_o, 0);
    rst_i = 1'b0;
    rdy_val = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", wr_valid_o, 0);
      chk("post_rst_idle", in_ready_o, 0);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
